// File: rtl/pipe_hazard_ctrl.sv
// Unified hazard controller for a 5-stage pipeline: forwarding, load-use stalls, load-wait freeze,
// branch/jump flushes and drain-then-halt. Define HAZ_PERF_CNT_EN to add saturating event counters.
module pipe_hazard_ctrl #(
    parameter int RA_W      = 3,
    parameter int ZERO_REG  = 0,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_jump,
    input  logic            ex_branch_taken,
    input  logic            mem_ready,
    input  logic            halt_req,
    output logic            stall_if,
    output logic            stall_id,
    output logic            flush_ifid,
    output logic            bubble_ex,
    output logic            freeze_all,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            halted,
    output logic [2:0]      state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_LOAD_WAIT  = 3'd1,
        ST_HALT_DRAIN = 3'd2,
        ST_HALTED     = 3'd3
    } state_e;

    localparam int                DC_W    = $clog2(DRAIN_CYC);
    localparam logic [DC_W-1:0]   DC_LAST = DC_W'(DRAIN_CYC - 1);

    if (DRAIN_CYC < 3 || CNT_W < 1) begin : g_param_check
        $error("pipe_hazard_ctrl: DRAIN_CYC must be >= 3 and CNT_W >= 1");
    end

    state_e          state_q, state_d;
    logic [DC_W-1:0] cnt_q, cnt_d;
    logic            halt_pend_q, halt_pend_d;

    // Shadow pipeline: only the metadata needed for hazard decisions
    logic [RA_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic            ex_rw_q, ex_mr_q;
    logic [RA_W-1:0] mem_rd_q;
    logic            mem_rw_q, mem_mr_q;
    logic [RA_W-1:0] wb_rd_q;
    logic            wb_rw_q;

    logic load_wait, load_use, flush_req, halt_any, ex_kill;

    function automatic logic live_rd(input logic [RA_W-1:0] r);
        return (ZERO_REG == 0) || (r != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic [RA_W-1:0] m_rd,
        input logic            m_rw,
        input logic            m_mr,
        input logic [RA_W-1:0] w_rd,
        input logic            w_rw
    );
        // A load in MEM has no data yet; the load-use stall keeps consumers out of EX
        if (m_rw && !m_mr && live_rd(m_rd) && (m_rd == src)) return 2'b01;
        if (w_rw && live_rd(w_rd) && (w_rd == src))          return 2'b10;
        return 2'b00;
    endfunction

    assign load_wait = mem_mr_q & ~mem_ready;
    assign flush_req = ex_branch_taken | id_jump;
    assign halt_any  = halt_req | halt_pend_q;
    assign load_use  = ex_mr_q & ex_rw_q & live_rd(ex_rd_q)
                     & ((id_use1 & (ex_rd_q == id_rs1)) | (id_use2 & (ex_rd_q == id_rs2)));

    assign fwd_a = fwd_sel(ex_rs1_q, mem_rd_q, mem_rw_q, mem_mr_q, wb_rd_q, wb_rw_q);
    assign fwd_b = fwd_sel(ex_rs2_q, mem_rd_q, mem_rw_q, mem_mr_q, wb_rd_q, wb_rw_q);
    assign state = state_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_ifid  = 1'b0;
        bubble_ex   = 1'b0;
        freeze_all  = 1'b0;
        halted      = 1'b0;
        ex_kill     = 1'b0;

        if (reset_n) begin
            if (load_wait && state_q != ST_HALTED) begin
                freeze_all = 1'b1;
                stall_if   = 1'b1;
                stall_id   = 1'b1;
            end else begin
                case (state_q)
                    ST_RUN, ST_LOAD_WAIT: begin
                        flush_ifid = flush_req;
                        bubble_ex  = ex_branch_taken;
                        // A flush makes the stalled instruction wrong-path, so the stall is dropped
                        if (!flush_req && load_use) begin
                            stall_if  = 1'b1;
                            stall_id  = 1'b1;
                            bubble_ex = 1'b1;
                        end
                    end
                    ST_HALT_DRAIN: begin
                        stall_if   = 1'b1;
                        bubble_ex  = 1'b1;
                        flush_ifid = flush_req;
                    end
                    ST_HALTED: begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        halted   = 1'b1;
                        ex_kill  = 1'b1;
                    end
                    default: ;
                endcase
            end

            case (state_q)
                ST_RUN: begin
                    if (load_wait) begin
                        state_d     = ST_LOAD_WAIT;
                        halt_pend_d = halt_any;
                    end else if (halt_any && !flush_req) begin
                        state_d     = ST_HALT_DRAIN;
                        cnt_d       = '0;
                        halt_pend_d = 1'b0;
                    end
                end
                ST_LOAD_WAIT: begin
                    halt_pend_d = halt_any;
                    if (!load_wait) state_d = ST_RUN;
                end
                ST_HALT_DRAIN: begin
                    if (!load_wait) begin
                        if (cnt_q == DC_LAST) state_d = ST_HALTED;
                        else                  cnt_d   = cnt_q + DC_W'(1);
                    end
                end
                ST_HALTED: ;
                default: state_d = ST_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            mem_mr_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
        end else if (!freeze_all) begin
            if (bubble_ex || flush_ifid || ex_kill) begin
                ex_rs1_q <= '0;
                ex_rs2_q <= '0;
                ex_rd_q  <= '0;
                ex_rw_q  <= 1'b0;
                ex_mr_q  <= 1'b0;
            end else begin
                ex_rs1_q <= id_rs1;
                ex_rs2_q <= id_rs2;
                ex_rd_q  <= id_rd;
                ex_rw_q  <= id_regwrite;
                ex_mr_q  <= id_memread;
            end
            mem_rd_q <= ex_rd_q;
            mem_rw_q <= ex_rw_q;
            mem_mr_q <= ex_mr_q;
            wb_rd_q  <= mem_rd_q;
            wb_rw_q  <= mem_rw_q;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, freeze_cnt_q, flush_cnt_q;

    // stall_id together with bubble_ex only occurs for a load-use stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (stall_id && bubble_ex && stall_cnt_q != '1) stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
            if (freeze_all && freeze_cnt_q != '1)          freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
            if (flush_ifid && flush_cnt_q != '1)           flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares. Built with ZERO_REG=1; counter checks run when HAZ_PERF_CNT_EN is set.
module tb_pipe_hazard_ctrl;

    localparam int RA_W  = 3;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            use1;
        logic            use2;
        logic [RA_W-1:0] rd;
        logic            rw;
        logic            mr;
        logic            jump;
        logic            br;
        logic            ready;
        logic            halt;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic            id_use1, id_use2, id_regwrite, id_memread, id_jump;
    logic            ex_branch_taken, mem_ready, halt_req;
    logic            stall_if, stall_id, flush_ifid, bubble_ex, freeze_all, halted;
    logic [1:0]      fwd_a, fwd_b;
    logic [2:0]      state;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, freeze_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .RA_W(RA_W), .ZERO_REG(1), .DRAIN_CYC(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready), .halt_req(halt_req),
        .stall_if(stall_if), .stall_id(stall_id), .flush_ifid(flush_ifid), .bubble_ex(bubble_ex),
        .freeze_all(freeze_all), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .state(state)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Observed vector order: {stall_if, stall_id, flush_ifid, bubble_ex, freeze_all, fwd_a, fwd_b, halted, state}
    logic [12:0] obs;
    assign obs = {stall_if, stall_id, flush_ifid, bubble_ex, freeze_all, fwd_a, fwd_b, halted, state};

    logic [12:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [12:0] ex(input logic si, input logic sd, input logic fl, input logic bu,
                                       input logic fr, input logic [1:0] fa, input logic [1:0] fb,
                                       input logic ha, input logic [2:0] st);
        return {si, sd, fl, bu, fr, fa, fb, ha, st};
    endfunction

    function automatic vec_t op(input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                                input logic u1, input logic u2, input logic [RA_W-1:0] rd,
                                input logic rw, input logic mr);
        vec_t v;
        v       = '0;
        v.rs1   = rs1;
        v.rs2   = rs2;
        v.use1  = u1;
        v.use2  = u2;
        v.rd    = rd;
        v.rw    = rw;
        v.mr    = mr;
        v.ready = 1'b1;
        return v;
    endfunction

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        logic [12:0] e;
        string       n;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, {3'b000, obs}, {3'b000, e});
        end
    end

    task automatic step(input string name, input logic rst_n, input vec_t v, input logic [12:0] e);
        @(posedge clk);
        #1;
        reset_n         = rst_n;
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_use1         = v.use1;
        id_use2         = v.use2;
        id_rd           = v.rd;
        id_regwrite     = v.rw;
        id_memread      = v.mr;
        id_jump         = v.jump;
        ex_branch_taken = v.br;
        mem_ready       = v.ready;
        halt_req        = v.halt;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    initial begin
        vec_t        nop, v;
        logic [12:0] z;
        nop = op(0, 0, 0, 0, 0, 0, 0);
        z   = ex(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd0);
        reset_n = 1'b1;
        {id_rs1, id_rs2, id_rd, id_use1, id_use2, id_regwrite, id_memread} = '0;
        {id_jump, ex_branch_taken, halt_req} = '0;
        mem_ready = 1'b1;
        #2 reset_n = 1'b0;

        step("reset_a", 0, nop, z);
        step("reset_b", 0, nop, z);
        step("reset_release", 1, nop, z);

        // lw r2 ; add r3,r2,r1 -> one stall cycle, then WB forward on rs1
        step("lu_load", 1, op(5, 0, 1, 0, 2, 1, 1), z);
        step("lu_stall", 1, op(2, 1, 1, 1, 3, 1, 0), ex(1, 1, 0, 1, 0, 2'd0, 2'd0, 0, 3'd0));
        step("lu_held", 1, op(2, 1, 1, 1, 3, 1, 0), z);
        step("lu_fwd_wb", 1, nop, ex(0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 3'd0));
        step("lu_tail", 1, nop, z);

        // add r1 ; sub r4,r1,r1 -> MEM forward on both operands
        step("alu_add", 1, op(6, 7, 1, 1, 1, 1, 0), z);
        step("alu_sub", 1, op(1, 1, 1, 1, 4, 1, 0), z);
        step("fwd_mem_ab", 1, nop, ex(0, 0, 0, 0, 0, 2'd1, 2'd1, 0, 3'd0));
        step("alu_tail", 1, nop, z);

        // Writes to r0 never forward
        step("r0_add", 1, op(5, 6, 1, 1, 0, 1, 0), z);
        step("r0_sub", 1, op(0, 0, 1, 1, 5, 1, 0), z);
        step("r0_mem_nofwd", 1, nop, z);
        step("r0_wb_nofwd", 1, nop, z);

        // Load waits 4 cycles in MEM; dependent add forwards correctly afterwards
        step("lw_load", 1, op(4, 0, 1, 0, 3, 1, 1), z);
        step("lw_or", 1, op(4, 5, 1, 1, 6, 1, 0), z);
        v = op(3, 6, 1, 1, 7, 1, 0);
        v.ready = 1'b0;
        step("lw_freeze_1", 1, v, ex(1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 3'd0));
        for (int i = 0; i < 3; i++)
            step("lw_freeze_n", 1, v, ex(1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 3'd1));
        v.ready = 1'b1;
        step("lw_release", 1, v, ex(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd1));
        step("lw_fwd_after", 1, nop, ex(0, 0, 0, 0, 0, 2'd2, 2'd1, 0, 3'd0));
        step("lw_tail", 1, nop, z);

        // Branch taken coinciding with load-use: flush wins, stall dropped; then a jump
        step("br_load", 1, op(0, 0, 0, 0, 2, 1, 1), z);
        v = op(2, 1, 1, 1, 3, 1, 0);
        v.br = 1'b1;
        step("br_over_lu", 1, v, ex(0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 3'd0));
        step("br_after", 1, nop, z);
        v = nop;
        v.jump = 1'b1;
        step("jump_flush", 1, v, ex(0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 3'd0));
        step("jump_after", 1, nop, z);

        // Halt: three drain cycles (branch still flushes), then halted until reset
        v = nop;
        v.halt = 1'b1;
        step("halt_req", 1, v, z);
        step("drain_0", 1, nop, ex(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 3'd2));
        v = nop;
        v.br = 1'b1;
        step("drain_1_br", 1, v, ex(1, 0, 1, 1, 0, 2'd0, 2'd0, 0, 3'd2));
        step("drain_2", 1, nop, ex(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 3'd2));
        step("halted_a", 1, nop, ex(1, 1, 0, 0, 0, 2'd0, 2'd0, 1, 3'd3));
        step("halted_b", 1, nop, ex(1, 1, 0, 0, 0, 2'd0, 2'd0, 1, 3'd3));
        step("halted_reset", 0, nop, z);
        step("halted_rel", 1, nop, z);

        // Reset during LOAD_WAIT clears the shadow load, so no freeze afterwards
        step("rlw_load", 1, op(0, 0, 0, 0, 1, 1, 1), z);
        step("rlw_nop", 1, nop, z);
        v = nop;
        v.ready = 1'b0;
        step("rlw_freeze_0", 1, v, ex(1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 3'd0));
        step("rlw_freeze_1", 1, v, ex(1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 3'd1));
        step("rlw_reset", 0, v, z);
        step("rlw_after", 1, v, z);

        // halt_req during a load wait is held and taken on return to RUN
        step("hp_load", 1, op(0, 0, 0, 0, 1, 1, 1), z);
        step("hp_nop", 1, nop, z);
        v = nop;
        v.ready = 1'b0;
        v.halt  = 1'b1;
        step("hp_freeze_req", 1, v, ex(1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 3'd0));
        v.halt = 1'b0;
        step("hp_freeze", 1, v, ex(1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 3'd1));
        step("hp_release", 1, nop, ex(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd1));
        step("hp_run", 1, nop, z);
        step("hp_drain", 1, nop, ex(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 3'd2));
        step("hp_reset", 0, nop, z);
        step("hp_rel", 1, nop, z);

`ifdef HAZ_PERF_CNT_EN
        // 20 load-wait cycles saturate a 4-bit freeze counter at 15
        step("pc_load", 1, op(0, 0, 0, 0, 1, 1, 1), z);
        step("pc_nop", 1, nop, z);
        v = nop;
        v.ready = 1'b0;
        step("pc_freeze_0", 1, v, ex(1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 3'd0));
        for (int i = 1; i < 20; i++)
            step("pc_freeze_n", 1, v, ex(1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 3'd1));
        step("pc_release", 1, nop, ex(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd1));
        check("freeze_cnt_sat", 16'(freeze_cnt), 16'd15);
        check("stall_cnt_zero", 16'(stall_cnt), 16'd0);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
